param_seq_detector: RTL and testbench

- Parametrised serial bit-sequence detector. Replaces the fixed-pattern, fixed-overlap detectors.
- Pattern, pattern length, overlap mode and output timing (Mealy or registered) are all set by parameters.
- Adds an input qualifier, a saturating match counter and a synchronous clear.
- Sits between a serial bit source (switch/UART bit stream) and LED/7-seg status logic. Exposes present/next state for debug.

---
 rtl/seq_det_pkg.sv | 69 ++++++
 rtl/seq_match_counter.sv | 33 +++
 rtl/param_seq_detector.sv | 105 ++++++++++
 tb/tb_param_seq_detector.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised sequence detector: state-width math
// and the constant functions that build the KMP transition table.
package seq_det_pkg;

  localparam int MAX_PAT_LEN = 16;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // State register width; a 1-bit minimum keeps tiny patterns legal.
  function automatic int state_w(input int len);
    int w;
    w = clog2(len);
    return (w < 1) ? 1 : w;
  endfunction

  // Bit idx of the pattern, read via a shift so the index width never matters.
  function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern, input int idx);
    logic [MAX_PAT_LEN-1:0] t;
    t = pattern >> idx;
    return t[0];
  endfunction

  // Longest proper border: a prefix shorter than len that is also a suffix.
  // Pattern bit [len-1] is the first bit on the wire.
  function automatic int border_len(input logic [MAX_PAT_LEN-1:0] pattern, input int len);
    int  best;
    logic ok;
    best = 0;
    for (int b = 1; b < len; b++) begin
      ok = 1'b1;
      for (int m = 0; m < b; m++) begin
        if (pat_bit(pattern, len - 1 - m) != pat_bit(pattern, b - 1 - m)) ok = 1'b0;
      end
      if (ok) best = b;
    end
    return best;
  endfunction

  // From state k (first k pattern bits seen) and a new bit, return the
  // longest j <= k+1 such that the history suffix equals the j-bit prefix.
  // A return value of len means the full pattern just completed.
  function automatic int kmp_next(input logic [MAX_PAT_LEN-1:0] pattern, input int len,
                                  input int state, input logic in_bit);
    int   best;
    int   hi;
    logic ok;
    logic hb;
    best = 0;
    for (int j = 1; j <= state + 1; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++) begin
          hi = state + 1 - j + m;
          hb = (hi < state) ? pat_bit(pattern, len - 1 - hi) : in_bit;
          if (hb != pat_bit(pattern, len - 1 - m)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear to zero, otherwise step until all ones and stick there.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, asynchronously zeroed by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/param_seq_detector.sv
// Parametrised serial pattern detector. The state is the length of the
// longest history suffix matching a proper pattern prefix; transitions come
// from a table computed at elaboration, so any pattern costs only a mux.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1,
  parameter int                 OUT_REG = 0,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = state_w(PAT_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [SW-1:0]    pre_s,
  output logic [SW-1:0]    next_s
);

  if ((PAT_LEN < 2) || (PAT_LEN > MAX_PAT_LEN)) begin : g_bad_len
    $error("param_seq_detector: PAT_LEN must be in 2..16");
  end

  localparam int                     NSTATES    = 2 ** SW;
  localparam logic [MAX_PAT_LEN-1:0] PAT16      = MAX_PAT_LEN'(PATTERN);
  localparam int                     BORDER     = border_len(PAT16, PAT_LEN);
  // Where the machine resumes after a full match.
  localparam logic [SW-1:0]          MATCH_NEXT = (OVERLAP != 0) ? SW'(BORDER) : {SW{1'b0}};
  localparam logic [SW-1:0]          LAST_STATE = SW'(PAT_LEN - 1);
  localparam logic                   LAST_BIT   = PATTERN[0];

  logic [SW-1:0] pre_q;
  logic [SW-1:0] next_d;
  logic [SW-1:0] tbl0 [NSTATES];
  logic [SW-1:0] tbl1 [NSTATES];
  logic          match;
  logic          match_ok;

  // Transition table per input bit. A completed pattern folds straight to
  // MATCH_NEXT; encodings past PAT_LEN-1 are unreachable and map to 0.
  for (genvar gi = 0; gi < NSTATES; gi++) begin : g_tbl
    if (gi < PAT_LEN) begin : g_live
      localparam int K0 = kmp_next(PAT16, PAT_LEN, gi, 1'b0);
      localparam int K1 = kmp_next(PAT16, PAT_LEN, gi, 1'b1);
      assign tbl0[gi] = (K0 >= PAT_LEN) ? MATCH_NEXT : SW'(K0);
      assign tbl1[gi] = (K1 >= PAT_LEN) ? MATCH_NEXT : SW'(K1);
    end else begin : g_dead
      assign tbl0[gi] = '0;
      assign tbl1[gi] = '0;
    end
  end

  // Next state: clear wins, idle cycles hold, otherwise look up the table.
  always_comb begin
    next_d = pre_q;
    if (clear) begin
      next_d = '0;
    end else if (en) begin
      if (32'(pre_q) < PAT_LEN) next_d = in ? tbl1[pre_q] : tbl0[pre_q];
      else                      next_d = '0;
    end
  end

  // Present-state register; reset drops any partial history at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= next_d;
  end

  assign match    = en & (pre_q == LAST_STATE) & (in == LAST_BIT);
  // A match under clear or reset is neither signalled nor counted.
  assign match_ok = match & ~clear & reset;

  if (OUT_REG != 0) begin : g_out_reg
    logic out_q;
    // One-cycle pulse on the cycle after the completing bit.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)     out_q <= 1'b0;
      else if (clear) out_q <= 1'b0;
      else            out_q <= match;
    end
    assign out = out_q;
  end else begin : g_out_mealy
    assign out = match_ok;
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .inc_i   (match_ok),
    .cnt_o   (match_cnt)
  );

  assign pre_s  = pre_q;
  assign next_s = next_d;

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: four configurations share one stimulus
// stream and are compared against a history-based reference model.
module tb_param_seq_detector;

  localparam int P_LEN  [4] = '{4, 4, 3, 4};
  localparam int P_PAT  [4] = '{11, 11, 1, 11};
  localparam int P_OVL  [4] = '{1, 0, 1, 1};
  localparam int P_OREG [4] = '{0, 0, 1, 0};
  localparam int P_CMAX [4] = '{255, 255, 255, 3};

  logic       clk = 1'b0;
  logic       reset, en, din, clear;
  logic       out_w [4];
  logic [1:0] pre_w [4];
  logic [1:0] nxt_w [4];
  logic [7:0] cnt_w [4];
  logic [1:0] cnt3;

  int checks = 0;
  int errors = 0;

  // Model: accepted history since last restart (newest bit in LSB).
  logic [31:0] mh [4];
  int          ml [4];
  int          mc [4];
  logic        mo [4];

  always #5 clk = ~clk;

  param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .OUT_REG(0), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .en(en), .in(din), .clear(clear),
    .out(out_w[0]), .match_cnt(cnt_w[0]), .pre_s(pre_w[0]), .next_s(nxt_w[0]));
  param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .OUT_REG(0), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .en(en), .in(din), .clear(clear),
    .out(out_w[1]), .match_cnt(cnt_w[1]), .pre_s(pre_w[1]), .next_s(nxt_w[1]));
  param_seq_detector #(.PAT_LEN(3), .PATTERN(3'b001), .OVERLAP(1), .OUT_REG(1), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .en(en), .in(din), .clear(clear),
    .out(out_w[2]), .match_cnt(cnt_w[2]), .pre_s(pre_w[2]), .next_s(nxt_w[2]));
  param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .OUT_REG(0), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .en(en), .in(din), .clear(clear),
    .out(out_w[3]), .match_cnt(cnt3), .pre_s(pre_w[3]), .next_s(nxt_w[3]));

  assign cnt_w[3] = {6'b0, cnt3};

  // Longest suffix of history (h, l bits) equal to a proper pattern prefix.
  function automatic int pfx(int i, logic [31:0] h, int l);
    int best = 0;
    for (int k = 1; k < P_LEN[i]; k++) begin
      if (k <= l && ((h & ((32'd1 << k) - 1)) == (32'(P_PAT[i]) >> (P_LEN[i] - k)))) best = k;
    end
    return best;
  endfunction

  // Does the current input complete the pattern?
  function automatic logic mmatch(int i);
    logic [31:0] h2;
    h2 = {mh[i][30:0], din};
    return reset && en && (ml[i] + 1 >= P_LEN[i]) &&
           ((h2 & ((32'd1 << P_LEN[i]) - 1)) == 32'(P_PAT[i]));
  endfunction

  function automatic logic m_out(int i);
    if (P_OREG[i] != 0) return mo[i];
    return mmatch(i) && !clear;
  endfunction

  function automatic logic [1:0] m_pre(int i);
    return 2'(pfx(i, mh[i], ml[i]));
  endfunction

  function automatic logic [1:0] m_nxt(int i);
    logic [31:0] h2;
    h2 = {mh[i][30:0], din};
    if (clear) return 2'd0;
    if (!en) return m_pre(i);
    if (mmatch(i) && P_OVL[i] == 0) return 2'd0;
    return 2'(pfx(i, h2, ml[i] + 1));
  endfunction

  function automatic logic [7:0] m_cnt(int i);
    return 8'(mc[i]);
  endfunction

  // Reference model state update.
  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset || clear) begin
        mh[i] <= '0; ml[i] <= 0; mc[i] <= 0; mo[i] <= 1'b0;
      end else begin
        mo[i] <= mmatch(i);
        if (mmatch(i) && mc[i] < P_CMAX[i]) mc[i] <= mc[i] + 1;
        if (en) begin
          if (mmatch(i) && P_OVL[i] == 0) begin
            mh[i] <= '0; ml[i] <= 0;
          end else begin
            mh[i] <= {mh[i][30:0], din};
            ml[i] <= (ml[i] < 24) ? ml[i] + 1 : 24;
          end
        end
      end
    end
  end

  task automatic drive(input logic e, input logic b, input logic c);
    @(negedge clk);
    en = e; din = b; clear = c;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; din = 1'b0; clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++; if (out_w[i] !== 1'b0) begin errors++; $display("FAIL reset.out inst%0d got %b exp 0", i, out_w[i]); end
        checks++; if (pre_w[i] !== 2'd0) begin errors++; $display("FAIL reset.pre inst%0d got %0d exp 0", i, pre_w[i]); end
        checks++; if (cnt_w[i] !== 8'd0) begin errors++; $display("FAIL reset.cnt inst%0d got %0d exp 0", i, cnt_w[i]); end
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_defaults();
    logic s [7]   = '{1, 0, 1, 1, 0, 1, 1};
    int   p0 [7]  = '{0, 1, 2, 3, 1, 2, 3};
    int   p1 [7]  = '{0, 1, 2, 3, 0, 0, 1};
    logic o0 [7]  = '{0, 0, 0, 1, 0, 0, 1};
    logic o1 [7]  = '{0, 0, 0, 1, 0, 0, 0};
    drive(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 7; t++) begin
      drive(1'b1, s[t], 1'b0);
      checks++; if (pre_w[0] !== 2'(p0[t])) begin errors++; $display("FAIL defaults.pre0 bit%0d got %0d exp %0d", t + 1, pre_w[0], p0[t]); end
      checks++; if (pre_w[1] !== 2'(p1[t])) begin errors++; $display("FAIL defaults.pre1 bit%0d got %0d exp %0d", t + 1, pre_w[1], p1[t]); end
      checks++; if (out_w[0] !== o0[t]) begin errors++; $display("FAIL defaults.out0 bit%0d got %b exp %b", t + 1, out_w[0], o0[t]); end
      checks++; if (out_w[1] !== o1[t]) begin errors++; $display("FAIL defaults.out1 bit%0d got %b exp %b", t + 1, out_w[1], o1[t]); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (nxt_w[i] !== m_nxt(i)) begin errors++; $display("FAIL defaults.nxt inst%0d got %0d exp %0d", i, nxt_w[i], m_nxt(i)); end
        checks++; if (cnt_w[i] !== m_cnt(i)) begin errors++; $display("FAIL defaults.cnt inst%0d got %0d exp %0d", i, cnt_w[i], m_cnt(i)); end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (cnt_w[0] !== 8'd2) begin errors++; $display("FAIL defaults.final_cnt0 got %0d exp 2", cnt_w[0]); end
    checks++; if (cnt_w[1] !== 8'd1) begin errors++; $display("FAIL defaults.final_cnt1 got %0d exp 1", cnt_w[1]); end
  endtask

  task automatic test_pattern001();
    logic s [8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
    logic o2 [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    drive(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 8; t++) begin
      drive(t < 7, s[t], 1'b0);
      checks++; if (out_w[2] !== o2[t]) begin errors++; $display("FAIL pat001.out cycle%0d got %b exp %b", t + 1, out_w[2], o2[t]); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (pre_w[i] !== m_pre(i)) begin errors++; $display("FAIL pat001.pre inst%0d got %0d exp %0d", i, pre_w[i], m_pre(i)); end
        checks++; if (out_w[i] !== m_out(i)) begin errors++; $display("FAIL pat001.out inst%0d got %b exp %b", i, out_w[i], m_out(i)); end
      end
    end
    checks++; if (cnt_w[2] !== 8'd2) begin errors++; $display("FAIL pat001.cnt got %0d exp 2", cnt_w[2]); end
  endtask

  task automatic test_gap();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checks++; if (pre_w[0] !== 2'd3) begin errors++; $display("FAIL gap.pre gap%0d got %0d exp 3", g, pre_w[0]); end
      checks++; if (out_w[0] !== 1'b0) begin errors++; $display("FAIL gap.out gap%0d got %b exp 0", g, out_w[0]); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (nxt_w[i] !== m_nxt(i)) begin errors++; $display("FAIL gap.nxt inst%0d got %0d exp %0d", i, nxt_w[i], m_nxt(i)); end
      end
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (out_w[0] !== 1'b1) begin errors++; $display("FAIL gap.match got %b exp 1", out_w[0]); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    en = 1'b0;
    checks++; if (pre_w[0] !== 2'd3) begin errors++; $display("FAIL areset.pre_before got %0d exp 3", pre_w[0]); end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pre_w[i] !== 2'd0) begin errors++; $display("FAIL areset.pre inst%0d got %0d exp 0", i, pre_w[i]); end
      checks++; if (cnt_w[i] !== 8'd0) begin errors++; $display("FAIL areset.cnt inst%0d got %0d exp 0", i, cnt_w[i]); end
      checks++; if (out_w[i] !== 1'b0) begin errors++; $display("FAIL areset.out inst%0d got %b exp 0", i, out_w[i]); end
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    checks++; if (out_w[0] !== 1'b0) begin errors++; $display("FAIL areset.no_match got %b exp 0", out_w[0]); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (cnt_w[0] !== 8'd0) begin errors++; $display("FAIL areset.cnt_after got %0d exp 0", cnt_w[0]); end
  endtask

  task automatic test_saturate_clear();
    logic [3:0] pat = 4'b1011;
    drive(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 20; t++) begin
      if (t == 19) begin
        checks++; if (cnt_w[3] !== 8'd3) begin errors++; $display("FAIL sat.cnt_before got %0d exp 3", cnt_w[3]); end
      end
      drive(1'b1, pat[3 - (t % 4)], t == 19);
      for (int i = 0; i < 4; i++) begin
        checks++; if (out_w[i] !== m_out(i)) begin errors++; $display("FAIL sat.out inst%0d bit%0d got %b exp %b", i, t + 1, out_w[i], m_out(i)); end
        checks++; if (cnt_w[i] !== m_cnt(i)) begin errors++; $display("FAIL sat.cnt inst%0d bit%0d got %0d exp %0d", i, t + 1, cnt_w[i], m_cnt(i)); end
      end
    end
    checks++; if (out_w[3] !== 1'b0) begin errors++; $display("FAIL sat.out_under_clear got %b exp 0", out_w[3]); end
    drive(1'b0, 1'b0, 1'b0);
    checks++; if (cnt_w[3] !== 8'd0) begin errors++; $display("FAIL sat.cnt_after_clear got %0d exp 0", cnt_w[3]); end
    checks++; if (pre_w[3] !== 2'd0) begin errors++; $display("FAIL sat.pre_after_clear got %0d exp 0", pre_w[3]); end
  endtask

  task automatic test_random();
    drive(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 600; t++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
      for (int i = 0; i < 4; i++) begin
        checks++; if (out_w[i] !== m_out(i)) begin errors++; $display("FAIL rand.out inst%0d cyc%0d got %b exp %b", i, t, out_w[i], m_out(i)); end
        checks++; if (pre_w[i] !== m_pre(i)) begin errors++; $display("FAIL rand.pre inst%0d cyc%0d got %0d exp %0d", i, t, pre_w[i], m_pre(i)); end
        checks++; if (nxt_w[i] !== m_nxt(i)) begin errors++; $display("FAIL rand.nxt inst%0d cyc%0d got %0d exp %0d", i, t, nxt_w[i], m_nxt(i)); end
        checks++; if (cnt_w[i] !== m_cnt(i)) begin errors++; $display("FAIL rand.cnt inst%0d cyc%0d got %0d exp %0d", i, t, cnt_w[i], m_cnt(i)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_pattern001();
    test_gap();
    test_async_reset();
    test_saturate_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
